// File: rtl/rreq_responder_pkg.sv
// rreq_responder_pkg: shared state type, default widths and pointer sizing for rreq_responder
package rreq_responder_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT_RTZ = 1'b1} rsp_state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/rreq_responder_hs_sync.sv
// hs_sync: STAGES-flop synchronizer for an asynchronous handshake line, reset to 0
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  always_ff @(posedge clk)
    if (!rst) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/rreq_responder.sv
// rreq_responder: 4-phase Rreq/Rack receiver buffering Rdata into a FIFO with a valid/ready output; RREQ_PARITY_EN adds Rpar/par_err
module rreq_responder
  import rreq_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Rreq,
  input  logic [DATA_W-1:0]        Rdata,
  output logic                     Rack,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef RREQ_PARITY_EN
  ,
  input  logic                     Rpar,
  output logic                     par_err
`endif
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  rsp_state_t state, state_n;
  logic req_s, full, empty, wr_en, rd_en;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  hs_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(Rreq), .q(req_s));
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign rd_en = !empty && out_ready;
  // full comes from registered pointers, so a same-cycle pop cannot enable a write
  always_comb begin
    state_n = state;
    wr_en = 1'b0;
    wr_en = state == IDLE && req_s && !full;
    state_n = state == IDLE ? (wr_en ? WAIT_RTZ : IDLE) : (req_s ? WAIT_RTZ : IDLE);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= Rdata;
`ifdef RREQ_PARITY_EN
  always_ff @(posedge clk)
    if (!rst) par_err <= 1'b0;
    else if (wr_en && (^{Rdata, Rpar})) par_err <= 1'b1;
`endif
  assign Rack = state == WAIT_RTZ;
  assign out_valid = !empty;
  assign out_data = mem[rd_ptr[AW-1:0]];
  assign fifo_count = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_rreq_responder.sv
// tb_rreq_responder: directed checks of handshake latency, back-pressure, drain, wrap, reset and parity
module tb_rreq_responder;
  logic clk = 1'b0, rst = 1'b0, Rreq = 1'b0, out_ready = 1'b0, Rack, out_valid;
  logic [7:0] Rdata = 8'h00, out_data;
  logic [2:0] fifo_count;
  int errors = 0, checks = 0;
  logic collect = 1'b0;
  int max_cnt = 0;
  logic [7:0] got[$];
`ifdef RREQ_PARITY_EN
  logic bad_par = 1'b0, par_err;
`endif
  rreq_responder dut (
    .clk(clk), .rst(rst), .Rreq(Rreq), .Rdata(Rdata), .Rack(Rack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count)
`ifdef RREQ_PARITY_EN
    , .Rpar((^Rdata) ^ bad_par), .par_err(par_err)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (collect) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  // full 4-phase cycle; up/dn are cycles to Rack rise/fall, -1 if the bound expired
  task automatic xfer(input logic [7:0] d, output int up, output int dn);
    Rreq = 1'b1;
    Rdata = d;
    up = -1;
    for (int i = 1; i <= 60 && up < 0; i++) begin
      @(negedge clk);
      if (Rack) up = i;
    end
    Rreq = 1'b0;
    dn = -1;
    for (int i = 1; i <= 60 && dn < 0; i++) begin
      @(negedge clk);
      if (!Rack) dn = i;
    end
  endtask
  task automatic test_reset;
    rst = 1'b0;
    step(2);
    checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL reset_rack got=%b exp=0", Rack); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    rst = 1'b1;
    step(1);
  endtask
  task automatic test_single;
    int dn;
    Rreq = 1'b1;
    Rdata = 8'hA5;
    step(2);
    checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL single_rack_early got=%b exp=0", Rack); end
    step(1);
    checks++; if (Rack !== 1'b1) begin errors++; $display("FAIL single_rack_rise got=%b exp=1", Rack); end
    step(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", out_data); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    Rreq = 1'b0;
    step(2);
    checks++; if (Rack !== 1'b1) begin errors++; $display("FAIL single_rack_hold got=%b exp=1", Rack); end
    step(1);
    checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL single_rack_fall got=%b exp=0", Rack); end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop got=%b exp=0", out_valid); end
    dn = 0;
  endtask
  task automatic test_full;
    int up, dn;
    logic stayed;
    for (int w = 1; w <= 4; w++) begin
      xfer(8'(w), up, dn);
      checks++; if (up != 3 || dn != 3) begin errors++; $display("FAIL fill_latency word=%0d got=%0d/%0d exp=3/3", w, up, dn); end
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", fifo_count); end
    Rreq = 1'b1;
    Rdata = 8'h05;
    stayed = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (Rack !== 1'b0) stayed = 1'b0;
    end
    checks++; if (stayed !== 1'b1) begin errors++; $display("FAIL full_backpressure got=%b exp=1", stayed); end
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL full_head got=%h exp=01", out_data); end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++; if (Rack !== 1'b0 || fifo_count !== 3'd3) begin errors++; $display("FAIL pop_no_write got=%b/%0d exp=0/3", Rack, fifo_count); end
    step(1);
    checks++; if (Rack !== 1'b1 || fifo_count !== 3'd4) begin errors++; $display("FAIL late_write got=%b/%0d exp=1/4", Rack, fifo_count); end
    Rreq = 1'b0;
    dn = -1;
    for (int i = 1; i <= 60 && dn < 0; i++) begin
      step(1);
      if (!Rack) dn = i;
    end
    checks++; if (dn != 3) begin errors++; $display("FAIL full_fall got=%0d exp=3", dn); end
  endtask
  task automatic test_drain;
    out_ready = 1'b1;
    for (int w = 2; w <= 5; w++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'(w)) begin errors++; $display("FAIL drain word=%0d got=%b/%h", w, out_valid, out_data); end
      step(1);
    end
    checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL drain_empty got=%b/%0d exp=0/0", out_valid, fifo_count); end
  endtask
  task automatic test_back_to_back;
    int up, dn;
    out_ready = 1'b1;
    got.delete();
    max_cnt = 0;
    collect = 1'b1;
    for (int w = 0; w < 10; w++) xfer(8'h10 + 8'(w), up, dn);
    step(2);
    collect = 1'b0;
    checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_size got=%0d exp=10", got.size()); end
    for (int w = 0; w < 10 && w < got.size(); w++) begin
      checks++; if (got[w] !== 8'h10 + 8'(w)) begin errors++; $display("FAIL wrap_word idx=%0d got=%h exp=%h", w, got[w], 8'h10 + 8'(w)); end
    end
    checks++; if (max_cnt > 2) begin errors++; $display("FAIL wrap_max_count got=%0d exp<=2", max_cnt); end
  endtask
  task automatic test_reset_mid;
    int up, dn;
    out_ready = 1'b0;
    xfer(8'h20, up, dn);
    Rreq = 1'b1;
    Rdata = 8'h21;
    up = -1;
    for (int i = 1; i <= 60 && up < 0; i++) begin
      step(1);
      if (Rack) up = i;
    end
    checks++; if (up != 3 || fifo_count !== 3'd2) begin errors++; $display("FAIL mid_setup got=%0d/%0d exp=3/2", up, fifo_count); end
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    checks++; if (Rack !== 1'b0 || fifo_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/0", Rack, fifo_count, out_valid); end
    step(2);
    checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL mid_rack_early got=%b exp=0", Rack); end
    step(1);
    checks++; if (Rack !== 1'b1 || fifo_count !== 3'd1) begin errors++; $display("FAIL mid_reack got=%b/%0d exp=1/1", Rack, fifo_count); end
    checks++; if (out_data !== 8'h21) begin errors++; $display("FAIL mid_data got=%h exp=21", out_data); end
    Rreq = 1'b0;
    step(3);
    checks++; if (Rack !== 1'b0) begin errors++; $display("FAIL mid_fall got=%b exp=0", Rack); end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask
`ifdef RREQ_PARITY_EN
  task automatic test_parity;
    int up, dn;
    out_ready = 1'b1;
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clean got=%b exp=0", par_err); end
    bad_par = 1'b1;
    xfer(8'h03, up, dn);
    bad_par = 1'b0;
    checks++; if (par_err !== 1'b1 || up != 3) begin errors++; $display("FAIL par_set got=%b/%0d exp=1/3", par_err, up); end
    xfer(8'h55, up, dn);
    checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_sticky got=%b exp=1", par_err); end
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_clear got=%b exp=0", par_err); end
  endtask
`endif
  initial begin
    test_reset;
    test_single;
    test_full;
    test_drain;
    test_back_to_back;
    test_reset_mid;
`ifdef RREQ_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
